// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and the alignment helper used by the top level.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Only the two low address bits decide alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr[0];
      F3_W:        mis = (addr != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte-lane mask and store-data replication on the way
// in, lane extraction with sign/zero extension on the way out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  lane_mask,
  output logic [31:0] wr_word,
  output logic [31:0] rd_ext
);

  logic [31:0] shifted;

  // funct3[1:0] carries the access size for both loads and stores.
  always_comb begin
    lane_mask = 4'b0000;
    wr_word   = wr_data;
    case (funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << addr_lo;
        wr_word   = {4{wr_data[7:0]}};
      end
      2'b01: begin
        lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word   = {2{wr_data[15:0]}};
      end
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    shifted = rd_word >> {addr_lo, 3'b000};
    rd_ext  = 32'h0;
    case (funct3)
      F3_B:    rd_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rd_ext = {24'h0, shifted[7:0]};
      F3_H:    rd_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rd_ext = {16'h0, shifted[15:0]};
      F3_W:    rd_ext = rd_word;
      default: rd_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle
// ready with err. Define DMEM_PARITY_EN to add per-byte even parity checking on loads.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [8:0]        addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: the core raises rd and/or wr and holds them (with addr, funct3,
  // wr_data) until it sees ready=1 for one cycle; the request is sampled once in
  // IDLE and the cycle after ready never starts a new access.

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  dmem_state_e state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, do_access;

  logic        a_wr, a_rd;
  logic [8:0]  a_addr;
  logic [2:0]  a_f3;
  logic [31:0] a_wdata;

  logic [31:0] mem [DEPTH];

  logic [6:0]  word_idx;
  logic        oor, misal, f3_bad, suppress, err_next, par_err;
  logic [31:0] rd_word, wr_word, rd_ext;
  logic [3:0]  lane_mask;

  assign dbg_state = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: if (rd || wr) begin
        accept     = 1'b1;
        cnt_next   = 4'(WAIT_CYCLES);
        state_next = WAIT;
      end
      WAIT: if (cnt == 4'd0) begin
        do_access  = 1'b1;
        state_next = DONE;
      end else begin
        cnt_next = cnt - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Legality of the latched request; rd+wr together is executed as a store.
  always_comb begin
    word_idx = a_addr[8:2];
    oor      = ({1'b0, word_idx} >= DEPTH_L);
    misal    = is_misaligned(a_f3, a_addr[1:0]);
    if (a_wr) f3_bad = !(a_f3 inside {F3_B, F3_H, F3_W});
    else      f3_bad = (a_f3 inside {3'b011, 3'b110, 3'b111});
    suppress = oor | misal | f3_bad;
    rd_word  = oor ? 32'h0 : mem[word_idx];
    err_next = suppress | (a_wr & a_rd) | (par_err & ~a_wr & ~suppress);
  end

  dmem_lane_align u_align (
    .funct3    (a_f3),
    .addr_lo   (a_addr[1:0]),
    .wr_data   (a_wdata),
    .rd_word   (rd_word),
    .lane_mask (lane_mask),
    .wr_word   (wr_word),
    .rd_ext    (rd_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      a_wr    <= 1'b0;
      a_rd    <= 1'b0;
      a_addr  <= 9'h0;
      a_f3    <= 3'h0;
      a_wdata <= 32'h0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        a_wr    <= wr;
        a_rd    <= rd;
        a_addr  <= addr;
        a_f3    <= funct3;
        a_wdata <= wr_data;
      end
      ready <= do_access;
      err   <= do_access & err_next;
      if (do_access) begin
        if (suppress)   rd_data <= '0;
        else if (!a_wr) rd_data <= rd_ext;
      end
    end
  end

  // Storage is not reset; a reset mid-request leaves state IDLE so nothing commits.
  always_ff @(posedge clk) begin
    if (do_access && a_wr && !suppress) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic [3:0] par_calc;

  always_comb begin
    for (int i = 0; i < 4; i++) par_calc[i] = ^rd_word[8*i +: 8];
    par_err = |(lane_mask & (par_calc ^ (oor ? 4'h0 : par[word_idx])));
  end

  always_ff @(posedge clk) begin
    if (do_access && a_wr && !suppress) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) par[word_idx][i] <= ^wr_word[8*i +: 8];
      end
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: two instances (WAIT_CYCLES 0 and 3) driven
// with directed load/store vectors; a negedge monitor checks every ready pulse.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int W = 34;  // {err, check_data, data}

  logic        clk = 1'b0;
  logic        rst_s [2];
  logic        wr_s  [2];
  logic        rd_s  [2];
  logic [8:0]  addr_s[2];
  logic [2:0]  f3_s  [2];
  logic [31:0] wd_s  [2];
  logic [31:0] rdd   [2];
  logic        rdy   [2];
  logic        er    [2];
  logic [1:0]  st    [2];

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  string        name_q0[$];
  string        name_q1[$];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .DEPTH(128), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst_s[0]), .wr(wr_s[0]), .rd(rd_s[0]), .addr(addr_s[0]),
    .funct3(f3_s[0]), .wr_data(wd_s[0]), .rd_data(rdd[0]), .ready(rdy[0]),
    .err(er[0]), .dbg_state(st[0])
  );

  dmem_responder #(.DATA_W(32), .DEPTH(128), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst_s[1]), .wr(wr_s[1]), .rd(rd_s[1]), .addr(addr_s[1]),
    .funct3(f3_s[1]), .wr_data(wd_s[1]), .rd_data(rdd[1]), .ready(rdy[1]),
    .err(er[1]), .dbg_state(st[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=0x%08h required=0x%08h", name, got, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  task automatic check_resp(input int i);
    logic [W-1:0] e;
    string        nm;
    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_ready inst=%0d got ready=1 required no pending request", i);
      return;
    end
    if (i == 0) begin e = exp_q0.pop_front(); nm = name_q0.pop_front(); end
    else        begin e = exp_q1.pop_front(); nm = name_q1.pop_front(); end
    check({nm, "_err"}, {31'h0, er[i]}, {31'h0, e[33]});
    if (e[32]) check({nm, "_data"}, rdd[i], e[31:0]);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] === 1'b1) check_resp(i);
    end
  end

  // Driver: holds the request until the edge after ready, like the core does.
  task automatic access(input int i, input logic do_wr, input logic do_rd,
                        input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d,
                        input logic exp_err, input logic chk, input logic [31:0] exp_data,
                        input string name);
    int lat;
    bit seen;
    if (i == 0) begin exp_q0.push_back({exp_err, chk, exp_data}); name_q0.push_back(name); end
    else        begin exp_q1.push_back({exp_err, chk, exp_data}); name_q1.push_back(name); end
    wr_s[i]   = do_wr;
    rd_s[i]   = do_rd;
    f3_s[i]   = f3;
    addr_s[i] = a;
    wd_s[i]   = d;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rdy[i] === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL %s_timeout got no ready in %0d cycles required ready", name, lat);
    end else if (lat != ((i == 0) ? 2 : 5)) begin
      n_miss++;
      $display("FAIL %s_latency got=%0d required=%0d", name, lat, (i == 0) ? 2 : 5);
    end
    @(posedge clk);
    #1;
    wr_s[i] = 1'b0;
    rd_s[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b0; wr_s[i] = 1'b0; rd_s[i] = 1'b0;
      addr_s[i] = 9'h0; f3_s[i] = 3'h0; wd_s[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_ready%0d", i), {31'h0, rdy[i]}, 32'h0);
      check($sformatf("reset_err%0d", i),   {31'h0, er[i]},  32'h0);
      check($sformatf("reset_rdata%0d", i), rdd[i],          32'h0);
      check($sformatf("reset_state%0d", i), {30'h0, st[i]},  32'(IDLE));
    end
    @(negedge clk);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;
    @(posedge clk);
    #1;

    // WAIT_CYCLES=0 instance
    access(0, 1, 0, F3_W,  9'h010, 32'hDEADBEEF, 0, 0, 32'h0,        "sw_010");
    access(0, 0, 1, F3_W,  9'h010, 32'h0,        0, 1, 32'hDEADBEEF, "lw_010");
    access(0, 0, 1, F3_B,  9'h013, 32'h0,        0, 1, 32'hFFFFFFDE, "lb_013");
    access(0, 0, 1, F3_BU, 9'h013, 32'h0,        0, 1, 32'h000000DE, "lbu_013");
    access(0, 0, 1, F3_H,  9'h012, 32'h0,        0, 1, 32'hFFFFDEAD, "lh_012");
    access(0, 0, 1, F3_HU, 9'h010, 32'h0,        0, 1, 32'h0000BEEF, "lhu_010");
    access(0, 1, 0, F3_B,  9'h011, 32'h00000055, 0, 0, 32'h0,        "sb_011");
    access(0, 0, 1, F3_W,  9'h010, 32'h0,        0, 1, 32'hDEAD55EF, "lw_after_sb");
    access(0, 0, 1, F3_W,  9'h012, 32'h0,        1, 1, 32'h0,        "lw_misaligned");
    access(0, 1, 0, F3_H,  9'h011, 32'h0000FFFF, 1, 1, 32'h0,        "sh_misaligned");
    access(0, 0, 1, F3_W,  9'h010, 32'h0,        0, 1, 32'hDEAD55EF, "lw_after_bad_sh");
    access(0, 1, 1, F3_W,  9'h020, 32'h12345678, 1, 0, 32'h0,        "rdwr_both");
    access(0, 0, 1, F3_W,  9'h020, 32'h0,        0, 1, 32'h12345678, "lw_after_both");
    access(0, 1, 0, 3'b100, 9'h020, 32'hFFFFFFFF, 1, 1, 32'h0,       "store_bad_f3");
    access(0, 0, 1, 3'b011, 9'h020, 32'h0,       1, 1, 32'h0,        "load_bad_f3");
    access(0, 0, 1, F3_W,  9'h020, 32'h0,        0, 1, 32'h12345678, "lw_after_bad_f3");
    access(0, 1, 0, F3_H,  9'h022, 32'h0000A5A5, 0, 0, 32'h0,        "sh_022");
    access(0, 0, 1, F3_W,  9'h020, 32'h0,        0, 1, 32'hA5A55678, "lw_after_sh");
    access(0, 0, 1, F3_B,  9'h021, 32'h0,        0, 1, 32'h00000056, "lb_021");
    access(0, 0, 1, F3_H,  9'h020, 32'h0,        0, 1, 32'h00005678, "lh_020");
    access(0, 0, 1, F3_B,  9'h022, 32'h0,        0, 1, 32'hFFFFFFA5, "lb_022");
    access(0, 0, 1, F3_HU, 9'h022, 32'h0,        0, 1, 32'h0000A5A5, "lhu_022");

    // WAIT_CYCLES=3 instance
    access(1, 1, 0, F3_W, 9'h040, 32'h0BADF00D, 0, 0, 32'h0,        "w3_sw_040");
    access(1, 0, 1, F3_W, 9'h040, 32'h0,        0, 1, 32'h0BADF00D, "w3_lw_040");

    // Reset in the middle of a store's wait states
    wr_s[1] = 1'b1; f3_s[1] = F3_W; addr_s[1] = 9'h040; wd_s[1] = 32'h11111111;
    repeat (2) @(posedge clk);
    #1;
    rst_s[1] = 1'b0;
    #1;
    check("midreset_ready", {31'h0, rdy[1]}, 32'h0);
    check("midreset_state", {30'h0, st[1]},  32'(IDLE));
    wr_s[1] = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_ready_hold", {31'h0, rdy[1]}, 32'h0);
    @(negedge clk);
    rst_s[1] = 1'b1;
    @(posedge clk);
    #1;
    access(1, 0, 1, F3_W, 9'h040, 32'h0, 0, 1, 32'h0BADF00D, "w3_lw_after_reset");

`ifdef DMEM_PARITY_EN
    u_w0.mem[8][0] = ~u_w0.mem[8][0];
    access(0, 0, 1, F3_W, 9'h020, 32'h0, 1, 0, 32'h0, "parity_flip");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("pending_inst0", 32'(exp_q0.size()), 32'h0);
    check("pending_inst1", 32'(exp_q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
